// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and received-byte bundle for uart_receiver
interface uart_receiver_if;
  logic       pin;
  logic [7:0] byte_received;
  logic       valid;
  logic       frame_error;

  modport master (
    input  pin,
    output byte_received,
    output valid,
    output frame_error
  );

  modport slave (
    output pin,
    input  byte_received,
    input  valid,
    input  frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_receiver #(
  parameter int clocks_per_bit = 434
) (
  input logic            clock,
  input logic            reset,
  uart_receiver_if.master rx
);

  localparam int cnt_w = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clocks_per_bit - 1);
  localparam logic [cnt_w-1:0] cnt_half = cnt_w'((clocks_per_bit - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             sync_1;
  logic             rx_s;

  // Synchronizer flops reset high so reset release never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx.pin;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shift_reg        <= 8'h00;
      rx.byte_received <= 8'h00;
      rx.valid         <= 1'b0;
      rx.frame_error   <= 1'b0;
    end else begin
      rx.valid       <= 1'b0;
      rx.frame_error <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        // Half a bit in, re-check the line so a short glitch is dropped.
        START: begin
          if (cnt == cnt_half) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == cnt_last) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == cnt_last) begin
            cnt <= '0;
            if (rx_s) begin
              rx.byte_received <= shift_reg;
              rx.valid         <= 1'b1;
              state            <= IDLE;
            end else begin
              rx.frame_error <= 1'b1;
              state          <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line is a break, not a stream of zero bytes.
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed bench for uart_receiver at 3, 16 and 434 clocks per bit
module tb_uart_receiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_receiver_if bus_a ();
  uart_receiver_if bus_b ();
  uart_receiver_if bus_c ();

  uart_receiver #(.clocks_per_bit(3))   dut_a (.clock(clock), .reset(reset), .rx(bus_a));
  uart_receiver #(.clocks_per_bit(16))  dut_b (.clock(clock), .reset(reset), .rx(bus_b));
  uart_receiver #(.clocks_per_bit(434)) dut_c (.clock(clock), .reset(reset), .rx(bus_c));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int per [3] = '{3, 16, 434};
  int fall_cyc [3];
  int n_valid [3];
  int n_fe [3];
  int n_both [3];
  logic [7:0] got_byte [3][16];
  int got_lat [3][16];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic record(input int s, input logic v, input logic fe, input logic [7:0] b);
    if (v) begin
      if (n_valid[s] < 16) begin
        got_byte[s][n_valid[s]] = b;
        got_lat[s][n_valid[s]]  = cyc - fall_cyc[s];
      end
      n_valid[s]++;
    end
    if (fe) n_fe[s]++;
    if (v && fe) n_both[s]++;
  endtask

  always @(negedge clock) begin
    record(0, bus_a.valid, bus_a.frame_error, bus_a.byte_received);
    record(1, bus_b.valid, bus_b.frame_error, bus_b.byte_received);
    record(2, bus_c.valid, bus_c.frame_error, bus_c.byte_received);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int s, input int idx);
    int lat;
    lat = got_lat[s][idx];
    vectors++;
    assert (2 * lat >= 19 * per[s] && 2 * lat <= 19 * per[s] + 8) else begin
      miscompares++;
      $error("FAIL %s: observed latency %0d expected %0d..%0d", tag, lat,
             (19 * per[s] + 1) / 2, (19 * per[s] + 8) / 2);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_pin(input int s, input logic v);
    case (s)
      0:       bus_a.pin = v;
      1:       bus_b.pin = v;
      default: bus_c.pin = v;
    endcase
  endtask

  // Leaves the line at the stop-bit level once the stop period ends.
  task automatic send_frame(input int s, input logic [7:0] data, input logic stop);
    set_pin(s, 1'b0);
    fall_cyc[s] = cyc;
    wait_cycles(per[s]);
    for (int i = 0; i < 8; i++) begin
      set_pin(s, data[i]);
      wait_cycles(per[s]);
    end
    set_pin(s, stop);
    wait_cycles(per[s]);
  endtask

  initial begin
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      n_valid[i] = 0; n_fe[i] = 0; n_both[i] = 0; fall_cyc[i] = 0;
    end
    bus_a.pin = 1'b1;
    bus_b.pin = 1'b1;
    bus_c.pin = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    check("reset_byte_a", {24'h0, bus_a.byte_received}, 32'h00);
    check("reset_valid_a", {31'h0, bus_a.valid}, 32'h0);
    check("reset_fe_a", {31'h0, bus_a.frame_error}, 32'h0);
    check("reset_byte_c", {24'h0, bus_c.byte_received}, 32'h00);
    reset = 1'b0;
    wait_cycles(8);
    check("release_no_valid", n_valid[0], 0);
    check("release_no_fe", n_fe[0], 0);

    send_frame(0, 8'hB9, 1'b1);
    wait_cycles(6);
    check("b9_count", n_valid[0], 1);
    check("b9_byte", {24'h0, got_byte[0][0]}, 32'hB9);
    check("b9_no_fe", n_fe[0], 0);
    check_lat("b9_latency", 0, 0);
    check("b9_hold", {24'h0, bus_a.byte_received}, 32'hB9);

    send_frame(0, 8'h55, 1'b1);
    send_frame(0, 8'hAA, 1'b1);
    wait_cycles(6);
    check("b2b_count", n_valid[0], 3);
    check("b2b_first", {24'h0, got_byte[0][1]}, 32'h55);
    check("b2b_second", {24'h0, got_byte[0][2]}, 32'hAA);
    check_lat("b2b_latency", 0, 2);

    set_pin(0, 1'b0);
    wait_cycles(1);
    set_pin(0, 1'b1);
    wait_cycles(12);
    check("glitch_no_valid", n_valid[0], 3);
    check("glitch_no_fe", n_fe[0], 0);
    check("glitch_hold", {24'h0, bus_a.byte_received}, 32'hAA);

    send_frame(0, 8'h3C, 1'b0);
    wait_cycles(20 * 3);
    check("brk_fe_count", n_fe[0], 1);
    check("brk_no_valid", n_valid[0], 3);
    check("brk_hold", {24'h0, bus_a.byte_received}, 32'hAA);
    set_pin(0, 1'b1);
    wait_cycles(6);
    send_frame(0, 8'h81, 1'b1);
    wait_cycles(6);
    check("after_brk_count", n_valid[0], 4);
    check("after_brk_byte", {24'h0, got_byte[0][3]}, 32'h81);
    check("after_brk_fe", n_fe[0], 1);

    d = 8'hF0;
    set_pin(0, 1'b0);
    wait_cycles(3);
    for (int i = 0; i < 4; i++) begin
      set_pin(0, d[i]);
      wait_cycles(3);
    end
    set_pin(0, d[4]);
    wait_cycles(1);
    reset = 1'b1;
    #1;
    check("abort_byte_zero", {24'h0, bus_a.byte_received}, 32'h00);
    wait_cycles(2);
    reset = 1'b0;
    set_pin(0, 1'b1);
    wait_cycles(36);
    check("abort_no_valid", n_valid[0], 4);
    check("abort_no_fe", n_fe[0], 1);
    check("abort_byte_held", {24'h0, bus_a.byte_received}, 32'h00);
    send_frame(0, 8'h0F, 1'b1);
    wait_cycles(6);
    check("abort_next_count", n_valid[0], 5);
    check("abort_next_byte", {24'h0, got_byte[0][4]}, 32'h0F);
    check_lat("abort_next_latency", 0, 4);

    send_frame(1, 8'hB9, 1'b1);
    wait_cycles(40);
    check("p16_count", n_valid[1], 1);
    check("p16_byte", {24'h0, got_byte[1][0]}, 32'hB9);
    check("p16_no_fe", n_fe[1], 0);
    check_lat("p16_latency", 1, 0);

    send_frame(2, 8'hB9, 1'b1);
    wait_cycles(1000);
    check("p434_count", n_valid[2], 1);
    check("p434_byte", {24'h0, got_byte[2][0]}, 32'hB9);
    check("p434_no_fe", n_fe[2], 0);
    check_lat("p434_latency", 2, 0);

    check("excl_a", n_both[0], 0);
    check("excl_b", n_both[1], 0);
    check("excl_c", n_both[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
